// File: rtl/stack_mem_responder.sv
// stack_mem_responder: stack RAM and stack pointer behind a one-at-a-time
// valid/ready request/response handshake (PUSH, POP, PEEK, CLEAR).
// Optional build macro: STACK_HIGH_WATER_EN. When it is defined,
// high_water tracks the peak occupancy since reset. When it is not
// defined, high_water is tied to zero.
module stack_mem_responder #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clock,
  input  logic             reset,       // synchronous, active-low
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic [AW:0]      sp,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      high_water
);

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_wdata;
  logic [AW:0]      r_sp;
  logic [WIDTH-1:0] r_rdata;
  logic             r_err;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_full;
  logic             w_empty;
  logic [AW:0]      w_sp_inc;
  logic [AW:0]      w_sp_dec;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;
  logic             w_do_push;

  // The full and empty checks guard every RAM access, so the narrow
  // indices below can never wrap onto a live entry.
  assign w_full    = (r_sp == SP_FULL);
  assign w_empty   = (r_sp == '0);
  assign w_sp_inc  = r_sp + (AW+1)'(1);
  assign w_sp_dec  = r_sp - (AW+1)'(1);
  assign w_wr_idx  = r_sp[AW-1:0];
  assign w_rd_idx  = r_sp[AW-1:0] - AW'(1);
  assign w_do_push = reset && (r_state == ST_EXEC) && (r_op == OP_PUSH) && !w_full;

  assign req_ready  = reset && (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign sp         = r_sp;
  assign full       = w_full;
  assign empty      = w_empty;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: IDLE -> EXEC -> RESP -> IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_state_next = ST_EXEC;
      ST_EXEC: w_state_next = ST_RESP;
      ST_RESP: if (resp_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Capture the request at the accepting edge
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_op    <= OP_PUSH;
      r_wdata <= '0;
    end else if (r_state == ST_IDLE && req_valid) begin
      r_op    <= req_op;
      r_wdata <= req_wdata;
    end
  end

  // Stack RAM write port. There is no reset here, so contents survive a reset.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[w_wr_idx] <= r_wdata;
  end

  // Execute the operation, then hold the response until it is consumed
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sp    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_EXEC: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
          case (r_op)
            OP_PUSH: begin
              if (w_full) r_err <= 1'b1;
              else        r_sp  <= w_sp_inc;
            end
            OP_POP: begin
              if (w_empty) begin
                r_err <= 1'b1;
              end else begin
                r_rdata <= r_mem[w_rd_idx];
                r_sp    <= w_sp_dec;
              end
            end
            OP_PEEK: begin
              if (w_empty) r_err   <= 1'b1;
              else         r_rdata <= r_mem[w_rd_idx];
            end
            OP_CLEAR: r_sp <= '0;
          endcase
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef STACK_HIGH_WATER_EN
  logic [AW:0] r_high_water;

  // Peak occupancy. Only a successful push can raise sp, and CLEAR never lowers the peak.
  always_ff @(posedge clock) begin
    if (!reset)                                    r_high_water <= '0;
    else if (w_do_push && w_sp_inc > r_high_water) r_high_water <= w_sp_inc;
  end

  assign high_water = r_high_water;
`else
  assign high_water = '0;
`endif

endmodule

// File: tb/tb_stack_mem_responder.sv
// Directed self-checking bench for stack_mem_responder (WIDTH=16, DEPTH=8).
// The expected high_water value follows STACK_HIGH_WATER_EN.
module tb_stack_mem_responder;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'b00;
  logic [WIDTH-1:0] req_wdata = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;
  logic [AW:0]      sp;
  logic             full;
  logic             empty;
  logic [AW:0]      high_water;

  int n_checks = 0;
  int n_errors = 0;

  stack_mem_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .sp         (sp),
    .full       (full),
    .empty      (empty),
    .high_water (high_water)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and consume its response. The task is called and returns on a falling edge.
  task automatic do_req(input logic [1:0] op, input logic [WIDTH-1:0] wd,
                        output logic [WIDTH-1:0] rd, output logic er);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
    req_op    = op;
    req_wdata = wd;
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!resp_valid) check("resp_valid_timeout", 32'd0, 32'd1);
    rd = resp_rdata;
    er = resp_err;
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    $display("txn op=%0d wdata=0x%04h -> rdata=0x%04h err=%0d sp=%0d hw=%0d",
             op, wd, rd, er, sp, high_water);
  endtask

  logic [WIDTH-1:0] rd;
  logic             er;
  logic [AW:0]      hw_exp;

  initial begin
    // Hold reset, then release it
    repeat (3) @(negedge clock);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_req_ready",  32'(req_ready),  32'd0);
    check("rst_sp",         32'(sp),         32'd0);
    check("rst_empty",      32'(empty),      32'd1);
    check("rst_full",       32'(full),       32'd0);
    check("rst_rdata",      32'(resp_rdata), 32'd0);
    check("rst_hw",         32'(high_water), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_req_ready", 32'(req_ready), 32'd1);

    // Fill the stack, then overflow it
    for (int i = 1; i <= DEPTH; i++) begin
      do_req(OP_PUSH, WIDTH'(i), rd, er);
      check("fill_err", 32'(er), 32'd0);
      check("fill_rdata", 32'(rd), 32'd0);
    end
    check("fill_sp",   32'(sp),   32'd8);
    check("fill_full", 32'(full), 32'd1);
`ifdef STACK_HIGH_WATER_EN
    hw_exp = 4'd8;
`else
    hw_exp = 4'd0;
`endif
    check("fill_hw", 32'(high_water), 32'(hw_exp));
    do_req(OP_PUSH, 16'hFFFF, rd, er);
    check("ovf_err", 32'(er), 32'd1);
    check("ovf_sp",  32'(sp), 32'd8);

    // LIFO drain, then underflow
    for (int i = DEPTH; i >= 1; i--) begin
      do_req(OP_POP, 16'h0000, rd, er);
      check("pop_rdata", 32'(rd), 32'(i));
      check("pop_err",   32'(er), 32'd0);
    end
    check("drain_sp",    32'(sp),    32'd0);
    check("drain_empty", 32'(empty), 32'd1);
    do_req(OP_POP, 16'h0000, rd, er);
    check("udf_err",   32'(er), 32'd1);
    check("udf_rdata", 32'(rd), 32'd0);
    do_req(OP_PEEK, 16'h0000, rd, er);
    check("peek_empty_err", 32'(er), 32'd1);

    // Latency, backpressure, and requests while the responder is busy
    check("lat_ready", 32'(req_ready), 32'd1);
    req_op = OP_PUSH; req_wdata = 16'h00A5; req_valid = 1'b1;
    @(negedge clock);                       // accepted; now in EXEC
    req_wdata = 16'h1234;                   // keep req_valid high while busy
    check("lat_exec_valid", 32'(resp_valid), 32'd0);
    check("lat_exec_ready", 32'(req_ready),  32'd0);
    @(negedge clock);                       // RESP, two cycles after the accepting cycle
    check("lat_resp_valid", 32'(resp_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_ready", 32'(req_ready),  32'd0);
      check("bp_rdata", 32'(resp_rdata), 32'd0);
      check("bp_err",   32'(resp_err),   32'd0);
      check("bp_sp",    32'(sp),         32'd1);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    check("bp_done_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clock);
    check("busy_no_resp", 32'(resp_valid), 32'd0);
    check("busy_sp",      32'(sp),         32'd1);
    do_req(OP_PEEK, 16'h0000, rd, er);
    check("peek_rdata", 32'(rd), 32'h00A5);
    check("peek_err",   32'(er), 32'd0);
    check("peek_sp",    32'(sp), 32'd1);

    // Reset while a response is pending
    req_op = OP_PUSH; req_wdata = 16'h0042; req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    check("mid_resp_valid", 32'(resp_valid), 32'd1);
    check("mid_sp",         32'(sp),         32'd2);
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_sp",    32'(sp),         32'd0);
    check("mid_rst_ready", 32'(req_ready),  32'd0);
    check("mid_rst_hw",    32'(high_water), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rel_ready", 32'(req_ready), 32'd1);

    // CLEAR and the high-water mark
    do_req(OP_PUSH, 16'h0011, rd, er);
    do_req(OP_PUSH, 16'h0022, rd, er);
    do_req(OP_PUSH, 16'h0033, rd, er);
    do_req(OP_POP,  16'h0000, rd, er);
    check("cl_pop_rdata", 32'(rd), 32'h0033);
    do_req(OP_CLEAR, 16'h0000, rd, er);
    check("clear_err",   32'(er),    32'd0);
    check("clear_sp",    32'(sp),    32'd0);
    check("clear_empty", 32'(empty), 32'd1);
`ifdef STACK_HIGH_WATER_EN
    hw_exp = 4'd3;
`else
    hw_exp = 4'd0;
`endif
    check("clear_hw", 32'(high_water), 32'(hw_exp));
    do_req(OP_PUSH, 16'h0044, rd, er);
    do_req(OP_PUSH, 16'h0055, rd, er);
    check("post_sp", 32'(sp),         32'd2);
    check("post_hw", 32'(high_water), 32'(hw_exp));
    do_req(OP_PEEK, 16'h0000, rd, er);
    check("post_peek", 32'(rd), 32'h0055);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time limit so that a stuck design cannot hang the run
  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
